keypad_matrix_emulator: RTL and testbench

Behavioural-synthesizable model of a 4x4 membrane keypad: the passive end of the row/column scan interface that keypad_peripheral drives. It accepts a key-press request over a valid/ready handshake and closes the addressed switch for a bounded time. During the close it answers the scanner's column strobes on the row lines, with programmable contact bounce on press and release. It is used in benches and on-board loopback to exercise the scanner and debouncer without a physical keypad.

---
 rtl/keypad_matrix_emulator_if.sv | 34 +++
 rtl/keypad_matrix_emulator.sv | 111 +++++++++++
 tb/tb_keypad_matrix_emulator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_emulator_if.sv
// Scanner-side bundle for the keypad emulator: press-request handshake plus
// the row/column matrix lines and the observation outputs.
interface keypad_matrix_emulator_if;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       busy;
  logic       contact;
  logic       key_done;

  modport master (
    output cols,
    output key_valid,
    output key_code,
    input  rows,
    input  key_ready,
    input  busy,
    input  contact,
    input  key_done
  );

  modport slave (
    input  cols,
    input  key_valid,
    input  key_code,
    output rows,
    output key_ready,
    output busy,
    output contact,
    output key_done
  );
endinterface

// File: rtl/keypad_matrix_emulator.sv
// Passive 4x4 keypad model: closes one addressed switch for a bounded time,
// with optional contact bounce on press and release, and answers column strobes.
module keypad_matrix_emulator #(
  parameter int BOUNCE_CYCLES = 8,
  parameter int BOUNCE_COUNT  = 3,
  parameter int HOLD_CYCLES   = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  keypad_matrix_emulator_if.slave  bus
);

  localparam int CNT_MAX = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SEG_N   = (BOUNCE_COUNT > 0) ? 2 * BOUNCE_COUNT : 1;
  localparam int SEG_W   = (SEG_N > 1) ? $clog2(SEG_N) : 1;

  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SEG_W-1:0] SEG_LAST    = SEG_W'(SEG_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [SEG_W-1:0] SEG_ONE     = SEG_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_B, HOLD, REL_B} state_t;

  state_t           state;
  logic [SEG_W-1:0] seg;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       code;
  logic             contact;
  logic             key_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      seg      <= '0;
      cnt      <= '0;
      code     <= '0;
      contact  <= 1'b0;
      key_done <= 1'b0;
    end else begin
      key_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            code    <= bus.key_code;
            contact <= 1'b1;
            seg     <= '0;
            cnt     <= '0;
            state   <= (BOUNCE_COUNT > 0) ? PRESS_B : HOLD;
          end
        end
        PRESS_B: begin
          // Even segments are closed, so the next segment's level is the current parity.
          if (cnt == BOUNCE_LAST) begin
            cnt <= '0;
            if (seg == SEG_LAST) begin
              seg     <= '0;
              contact <= 1'b1;
              state   <= HOLD;
            end else begin
              seg     <= seg + SEG_ONE;
              contact <= seg[0];
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt     <= '0;
            contact <= 1'b0;
            if (BOUNCE_COUNT > 0) begin
              state <= REL_B;
            end else begin
              state    <= IDLE;
              key_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        REL_B: begin
          // Release bounce is inverted: odd segments closed, ending on a closed segment.
          if (cnt == BOUNCE_LAST) begin
            cnt <= '0;
            if (seg == SEG_LAST) begin
              seg      <= '0;
              contact  <= 1'b0;
              state    <= IDLE;
              key_done <= 1'b1;
            end else begin
              seg     <= seg + SEG_ONE;
              contact <= ~seg[0];
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rows      = contact ? (4'(bus.cols[code[1:0]]) << code[3:2]) : 4'b0000;
  assign bus.key_ready = (state == IDLE) & rst_n;
  assign bus.busy      = (state != IDLE);
  assign bus.contact   = contact;
  assign bus.key_done  = key_done;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: a bouncing instance and a clean-edge instance,
// compared cycle by cycle against a timeline model of the press sequence.
module tb_keypad_matrix_emulator;

  localparam int BC    = 4;
  localparam int BN    = 2;
  localparam int HC    = 20;
  localparam int SEQ_A = 4 * BN * BC + HC;
  localparam int SEQ_B = HC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  keypad_matrix_emulator_if ia ();
  keypad_matrix_emulator_if ib ();

  keypad_matrix_emulator #(.BOUNCE_CYCLES(BC), .BOUNCE_COUNT(BN), .HOLD_CYCLES(HC)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  keypad_matrix_emulator #(.BOUNCE_CYCLES(BC), .BOUNCE_COUNT(0), .HOLD_CYCLES(HC)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  always #5 clk = ~clk;

  // Switch level i cycles after the accepting edge, from the press/hold/release timeline.
  function automatic bit model_contact(input int i, input int n, input int b, input int h);
    int press_len;
    press_len = 2 * n * b;
    if (i < press_len) return ((i / b) % 2) == 0;
    if (i < press_len + h) return 1'b1;
    if (i < 2 * press_len + h) return (((i - press_len - h) / b) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_rows(input bit c, input logic [3:0] code, input logic [3:0] cv);
    logic [3:0] r;
    r = 4'b0000;
    if (c && cv[code[1:0]]) r[code[3:2]] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] pick_cols(input int mode, input logic [3:0] fixed, input int i);
    case (mode)
      0:       return fixed;
      1:       return 4'(1 << (i % 4));
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // vmode: 0 drop key_valid after acceptance, 1 spam key_code=15 while busy, 2 hold key_valid
  task automatic press_a(input logic [3:0] code, input int cmode, input logic [3:0] fixed,
                         input int vmode, input string tag);
    logic [3:0] cv;
    logic [3:0] er;
    bit         ec;
    ia.key_code  = code;
    ia.key_valid = 1'b1;
    @(posedge clk); #1;
    if (vmode == 1) ia.key_code = 4'd15;
    else if (vmode == 0) ia.key_valid = 1'b0;
    for (int i = 0; i < SEQ_A; i++) begin
      cv = pick_cols(cmode, fixed, i);
      ia.cols = cv;
      @(negedge clk);
      ec = model_contact(i, BN, BC, HC);
      er = model_rows(ec, code, cv);
      checks++;
      if (ia.contact !== ec)
        $display("[TB] FAIL %s contact cyc=%0d got=%b exp=%b", tag, i, ia.contact, ec);
      else passes++;
      checks++;
      if (ia.rows !== er)
        $display("[TB] FAIL %s rows cyc=%0d cols=%b got=%b exp=%b", tag, i, cv, ia.rows, er);
      else passes++;
      checks++;
      if ({ia.busy, ia.key_ready, ia.key_done} !== 3'b100)
        $display("[TB] FAIL %s busy/ready/done cyc=%0d got=%b exp=100", tag, i,
                 {ia.busy, ia.key_ready, ia.key_done});
      else passes++;
      @(posedge clk); #1;
      if (vmode == 1 && i == SEQ_A - 3) ia.key_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({ia.key_done, ia.contact, ia.busy, ia.key_ready} !== 4'b1001 || ia.rows !== 4'b0000)
      $display("[TB] FAIL %s done_cycle got done/contact/busy/ready=%b rows=%b exp=1001 rows=0000",
               tag, {ia.key_done, ia.contact, ia.busy, ia.key_ready}, ia.rows);
    else passes++;
  endtask

  task automatic idle_check_a(input string tag);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({ia.key_done, ia.contact, ia.busy, ia.key_ready} !== 4'b0001)
      $display("[TB] FAIL %s idle got done/contact/busy/ready=%b exp=0001", tag,
               {ia.key_done, ia.contact, ia.busy, ia.key_ready});
    else passes++;
  endtask

  task automatic test_reset();
    ia.cols = 4'hF; ia.key_valid = 1'b0; ia.key_code = 4'h0;
    ib.cols = 4'hF; ib.key_valid = 1'b0; ib.key_code = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ia.contact, ia.key_done, ia.busy, ia.key_ready, ia.rows} !== 8'b0001_0000)
      $display("[TB] FAIL reset_a got c/d/b/r=%b rows=%b exp=0001 rows=0000",
               {ia.contact, ia.key_done, ia.busy, ia.key_ready}, ia.rows);
    else passes++;
    checks++;
    if ({ib.contact, ib.key_done, ib.busy, ib.key_ready, ib.rows} !== 8'b0001_0000)
      $display("[TB] FAIL reset_b got c/d/b/r=%b rows=%b exp=0001 rows=0000",
               {ib.contact, ib.key_done, ib.busy, ib.key_ready}, ib.rows);
    else passes++;
  endtask

  task automatic test_pattern();
    press_a(4'd5, 0, 4'b0010, 0, "pattern");
    idle_check_a("pattern");
  endtask

  task automatic test_rotating_cols();
    press_a(4'd5, 1, 4'b0000, 0, "rotating");
    idle_check_a("rotating");
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 3; n++) begin
      press_a(4'($urandom_range(0, 15)), 2, 4'b0000, 0, "random_key");
      idle_check_a("random_key");
    end
  endtask

  task automatic test_busy_ignored();
    press_a(4'd5, 2, 4'b0000, 1, "busy_ignored");
    idle_check_a("busy_ignored");
  endtask

  task automatic test_reset_midseq();
    int         k;
    logic [3:0] code;
    code = 4'($urandom_range(0, 15));
    k = $urandom_range(2 * BN * BC + 1, 2 * BN * BC + HC - 2);
    ia.cols = 4'(1 << code[1:0]);
    ia.key_code = code;
    ia.key_valid = 1'b1;
    @(posedge clk); #1;
    ia.key_valid = 1'b0;
    repeat (k) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ia.contact !== 1'b1 || ia.rows !== model_rows(1'b1, code, ia.cols))
      $display("[TB] FAIL midseq_hold got contact=%b rows=%b exp contact=1", ia.contact, ia.rows);
    else passes++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ia.contact, ia.key_done, ia.busy, ia.key_ready, ia.rows} !== 8'b0001_0000)
        $display("[TB] FAIL midseq_abort cyc=%0d got c/d/b/r=%b rows=%b exp=0001 rows=0000", i,
                 {ia.contact, ia.key_done, ia.busy, ia.key_ready}, ia.rows);
      else passes++;
      @(posedge clk); #1;
    end
    press_a(code, 0, 4'(1 << code[1:0]), 0, "after_reset");
    idle_check_a("after_reset");
  endtask

  task automatic test_back_to_back();
    press_a(4'd10, 0, 4'b0100, 2, "b2b_first");
    press_a(4'd10, 1, 4'b0000, 2, "b2b_second");
    ia.key_valid = 1'b0;
    idle_check_a("b2b");
  endtask

  task automatic test_clean_edges();
    logic [3:0] code;
    logic [3:0] cv;
    for (int run = 0; run < 2; run++) begin
      code = (run == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ib.key_code = code;
      ib.cols = (run == 0) ? 4'b0001 : 4'($urandom_range(0, 15));
      ib.key_valid = 1'b1;
      @(posedge clk); #1;
      ib.key_valid = 1'b0;
      for (int i = 0; i < SEQ_B; i++) begin
        if (run != 0) ib.cols = 4'($urandom_range(0, 15));
        cv = ib.cols;
        @(negedge clk);
        checks++;
        if (ib.contact !== model_contact(i, 0, BC, HC) || ib.rows !== model_rows(1'b1, code, cv) ||
            ib.key_done !== 1'b0 || ib.busy !== 1'b1)
          $display("[TB] FAIL clean run=%0d cyc=%0d got c=%b rows=%b d=%b b=%b exp c=1 rows=%b d=0 b=1",
                   run, i, ib.contact, ib.rows, ib.key_done, ib.busy, model_rows(1'b1, code, cv));
        else passes++;
        @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if ({ib.key_done, ib.contact, ib.busy, ib.key_ready} !== 4'b1001 || ib.rows !== 4'b0000)
        $display("[TB] FAIL clean_done run=%0d got d/c/b/r=%b rows=%b exp=1001 rows=0000", run,
                 {ib.key_done, ib.contact, ib.busy, ib.key_ready}, ib.rows);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  // Scenarios run in sequence; each leaves both instances idle.
  initial begin
    test_reset();
    test_pattern();
    test_rotating_cols();
    test_random_keys();
    test_busy_ignored();
    test_reset_midseq();
    test_back_to_back();
    test_clean_edges();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
